fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage pipeline.
- Tracks destination tags of in-flight instructions in its own EX/MEM/WB tag pipeline.
- Drives the 2-bit selects of the two ALU-operand 3-to-1 forwarding muxes.
- Detects load-use hazards and stalls IF/ID for one cycle, inserting an EX bubble; counts stall cycles for performance debug.

Parameters:
RW, 5, register-address width
CW, 16, stall-counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  RW  ID source register A
id_rt  input  RW  ID source register B
id_use_rs  input  1  ID instruction actually reads rs
id_use_rt  input  1  ID instruction actually reads rt
id_dest  input  RW  ID destination register
id_regwrite  input  1  ID instruction writes the register file
id_memread  input  1  ID instruction is a load
freeze  input  1  global pipeline hold (e.g. memory wait)
flush  input  1  squash ID instruction (taken branch/jump)
stall  output  1  hold PC and IF/ID this cycle
fwd_a_sel  output  2  ALU operand A mux select
fwd_b_sel  output  2  ALU operand B mux select
ex_bubble  output  1  EX stage currently holds a bubble
stall_count  output  CW  saturating count of stall cycles

Behaviour:
- Select encoding:
  - 00: register-file value.
  - 01: MEM/WB result.
  - 10: EX/MEM result.
  - 11 is never driven.
- Internal registers:
  - EX tag: valid, rs, rt, use_rs, use_rt, dest, regwrite, memread.
  - MEM tag: dest, regwrite.
  - WB tag: dest, regwrite.
- Reset (asynchronous, immediate):
  - All tags cleared; EX valid = 0.
  - stall_count = 0.
  - Outputs: fwd_a_sel = fwd_b_sel = 00, stall = 0, ex_bubble = 1.
- fwd_a_sel is combinational from registered tags:
  - 10 if ex_use_rs & mem_regwrite & mem_dest != 0 & mem_dest == ex_rs.
  - Else 01 if wb_regwrite & wb_dest != 0 & wb_dest == ex_rs.
  - Else 00.
  - EX/MEM has priority over MEM/WB.
- fwd_b_sel: identical rule using ex_rt and ex_use_rt.
- Register 0 is never forwarded.
- A bubble in EX (ex_valid = 0) forces both selects to 00.
- stall (combinational) =
  - id_valid & !flush & ex_valid & ex_memread & ex_regwrite & ex_dest != 0,
  - AND ((id_use_rs & id_rs == ex_dest) | (id_use_rt & id_rt == ex_dest)).
- Rising edge with freeze = 1: every tag and stall_count holds. stall and the selects stay combinational from held state.
- Rising edge with freeze = 0:
  - WB tag <= MEM tag.
  - MEM tag <= {ex_dest, ex_valid & ex_regwrite}.
  - EX tag <= bubble (valid = 0, regwrite = 0, memread = 0) if stall | flush | !id_valid; otherwise EX tag <= ID fields with valid = 1.
- stall_count increments on each edge where stall & !freeze; saturates at all-ones.
- Latency:
  - A load-use stall lasts exactly one cycle; the load advances to MEM, which clears the condition.
  - The consumer then reaches EX with the load in WB, so it receives 01.
- flush has priority over stall: stall = 0 whenever flush = 1, and the ID instruction becomes a bubble.
- Same-cycle WB write / ID read of the same register is resolved by the register file (write-first), not by this block.
- Invariant (assertion): the MEM stage never holds a load whose dest matches a used EX source.
- Reset mid-stall: stall drops immediately; EX becomes a bubble.

Test Plan:
- add r3 then add r4,r3,r5 back-to-back -> second instr in EX gets fwd_a_sel = 10, fwd_b_sel = 00, stall = 0.
- add r3; nop; sub r6,r2,r3 -> sub in EX gets fwd_b_sel = 01.
- Consecutive writes to r3, then a reader of r3 -> reader gets 10 (priority); writes/reads of r0 -> 00 always.
- lw r3; add r4,r3,r3:
  - stall = 1 for exactly one cycle; next cycle ex_bubble = 1.
  - add in EX gets fwd_a_sel = fwd_b_sel = 01.
  - stall_count = 1.
- Load-use with flush = 1 in the same cycle -> stall = 0; EX bubble; stall_count unchanged.
- freeze for 3 cycles during a load-use stall -> tags, selects, and stall_count hold. After release, one stall edge is counted. Asserting rst mid-sequence -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
// ---------------------------------------------------------------------------
// Forwarding and load-use hazard controller for a classic 5-stage pipeline.
// Keeps its own EX/MEM/WB destination-tag pipeline and, from those tags,
// drives the two ALU-operand forwarding mux selects. A load in EX whose
// destination is read by the instruction in ID stalls IF/ID for one cycle
// and turns the next EX slot into a bubble. Stall cycles are counted
// (saturating) for performance debug.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   id_*              decoded fields of the instruction currently in ID
//   freeze            global pipeline hold: all tags and the counter hold
//   flush             squash the ID instruction (becomes an EX bubble)
//   stall             hold PC and IF/ID this cycle (combinational)
//   fwd_a_sel/b_sel   00 = register file, 01 = MEM/WB, 10 = EX/MEM
//   ex_bubble         EX stage currently holds a bubble
//   stall_count       saturating count of stall cycles
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [RW-1:0] id_dest,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          freeze,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    fwd_a_sel,
  output logic [1:0]    fwd_b_sel,
  output logic          ex_bubble,
  output logic [CW-1:0] stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // EX tag
  logic          ex_valid_q,    ex_valid_d;
  logic [RW-1:0] ex_rs_q,       ex_rs_d;
  logic [RW-1:0] ex_rt_q,       ex_rt_d;
  logic          ex_use_rs_q,   ex_use_rs_d;
  logic          ex_use_rt_q,   ex_use_rt_d;
  logic [RW-1:0] ex_dest_q,     ex_dest_d;
  logic          ex_regwrite_q, ex_regwrite_d;
  logic          ex_memread_q,  ex_memread_d;
  // MEM tag (mem_load_q only feeds the hazard invariant check)
  logic [RW-1:0] mem_dest_q,     mem_dest_d;
  logic          mem_regwrite_q, mem_regwrite_d;
  logic          mem_load_q,     mem_load_d;
  // WB tag
  logic [RW-1:0] wb_dest_q,     wb_dest_d;
  logic          wb_regwrite_q, wb_regwrite_d;

  logic [CW-1:0] stall_count_q, stall_count_d;

  // Select for one operand. EX/MEM is checked first so the youngest
  // producer wins; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_select(input logic          valid,
                                             input logic          use_src,
                                             input logic [RW-1:0] src);
    logic [1:0] sel;
    sel = SEL_RF;
    if (valid && use_src) begin
      if (mem_regwrite_q && (mem_dest_q != '0) && (mem_dest_q == src))
        sel = SEL_MEM;
      else if (wb_regwrite_q && (wb_dest_q != '0) && (wb_dest_q == src))
        sel = SEL_WB;
    end
    return sel;
  endfunction

  assign fwd_a_sel = fwd_select(ex_valid_q, ex_use_rs_q, ex_rs_q);
  assign fwd_b_sel = fwd_select(ex_valid_q, ex_use_rt_q, ex_rt_q);
  assign ex_bubble = !ex_valid_q;

  // Load in EX feeding a source of the ID instruction. A flushed ID
  // instruction never stalls; it is discarded instead.
  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush && ex_valid_q && ex_memread_q && ex_regwrite_q &&
        (ex_dest_q != '0)) begin
      stall = (id_use_rs && (id_rs == ex_dest_q)) ||
              (id_use_rt && (id_rt == ex_dest_q));
    end
  end

  assign stall_count = stall_count_q;

  always_comb begin
    // default: hold everything (covers freeze)
    ex_valid_d     = ex_valid_q;
    ex_rs_d        = ex_rs_q;
    ex_rt_d        = ex_rt_q;
    ex_use_rs_d    = ex_use_rs_q;
    ex_use_rt_d    = ex_use_rt_q;
    ex_dest_d      = ex_dest_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_memread_d   = ex_memread_q;
    mem_dest_d     = mem_dest_q;
    mem_regwrite_d = mem_regwrite_q;
    mem_load_d     = mem_load_q;
    wb_dest_d      = wb_dest_q;
    wb_regwrite_d  = wb_regwrite_q;
    stall_count_d  = stall_count_q;

    if (!freeze) begin
      wb_dest_d      = mem_dest_q;
      wb_regwrite_d  = mem_regwrite_q;
      mem_dest_d     = ex_dest_q;
      mem_regwrite_d = ex_valid_q && ex_regwrite_q;
      mem_load_d     = ex_valid_q && ex_regwrite_q && ex_memread_q;

      if (stall || flush || !id_valid) begin
        // bubble: all fields cleared so a bubble never looks like a producer
        ex_valid_d    = 1'b0;
        ex_rs_d       = '0;
        ex_rt_d       = '0;
        ex_use_rs_d   = 1'b0;
        ex_use_rt_d   = 1'b0;
        ex_dest_d     = '0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
      end else begin
        ex_valid_d    = 1'b1;
        ex_rs_d       = id_rs;
        ex_rt_d       = id_rt;
        ex_use_rs_d   = id_use_rs;
        ex_use_rt_d   = id_use_rt;
        ex_dest_d     = id_dest;
        ex_regwrite_d = id_regwrite;
        ex_memread_d  = id_memread;
      end

      if (stall && (stall_count_q != {CW{1'b1}}))
        stall_count_d = stall_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_use_rs_q    <= 1'b0;
      ex_use_rt_q    <= 1'b0;
      ex_dest_q      <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_dest_q     <= '0;
      mem_regwrite_q <= 1'b0;
      mem_load_q     <= 1'b0;
      wb_dest_q      <= '0;
      wb_regwrite_q  <= 1'b0;
      stall_count_q  <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_use_rs_q    <= ex_use_rs_d;
      ex_use_rt_q    <= ex_use_rt_d;
      ex_dest_q      <= ex_dest_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_dest_q     <= mem_dest_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_load_q     <= mem_load_d;
      wb_dest_q      <= wb_dest_d;
      wb_regwrite_q  <= wb_regwrite_d;
      stall_count_q  <= stall_count_d;
    end
  end

  // A load in MEM must never have a dependent instruction in EX: the stall
  // is what guarantees that consumer sits behind a bubble.
  a_no_load_use_in_mem : assert property (@(posedge clk) disable iff (rst)
    !(mem_load_q && (mem_dest_q != '0) && ex_valid_q &&
      ((ex_use_rs_q && (ex_rs_q == mem_dest_q)) ||
       (ex_use_rt_q && (ex_rt_q == mem_dest_q)))));

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Testbench for fwd_hazard_ctrl. Each scenario is a table of per-cycle ID
// instructions with the hand-derived expected outputs for that cycle.
// Expected vectors are queued when the cycle is driven and popped when the
// outputs are sampled (1 time unit after the inputs change, mid-cycle).
module tb_fwd_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic          id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic          id_regwrite = 1'b0, id_memread = 1'b0;
  logic          freeze = 1'b0, flush = 1'b0;
  logic          stall;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          ex_bubble;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  // expected output vector: {stall, a_sel, b_sel, ex_bubble, stall_count}
  logic [21:0] sb[$];

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          urs;
    logic          urt;
    logic [RW-1:0] dest;
    logic          rw;
    logic          mr;
  } instr_t;

  typedef struct packed {
    instr_t      i;
    logic        frz;
    logic        fl;
    logic [21:0] exp;
  } step_t;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.RW(RW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .freeze(freeze), .flush(flush),
    .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .ex_bubble(ex_bubble), .stall_count(stall_count)
  );

  function automatic logic [21:0] obs();
    return {stall, fwd_a_sel, fwd_b_sel, ex_bubble, stall_count};
  endfunction

  function automatic logic [21:0] ev(logic s, logic [1:0] a, logic [1:0] b,
                                     logic bub, logic [15:0] c);
    return {s, a, b, bub, c};
  endfunction

  function automatic string fmt(logic [21:0] v);
    return $sformatf("stall=%b a=%b b=%b bubble=%b count=%0d",
                     v[21], v[20:19], v[18:17], v[16], v[15:0]);
  endfunction

  function automatic instr_t I(int rs, int rt, bit urs, bit urt, int dest,
                               bit rw, bit mr);
    instr_t x;
    x.v = 1'b1; x.rs = RW'(rs); x.rt = RW'(rt); x.urs = urs; x.urt = urt;
    x.dest = RW'(dest); x.rw = rw; x.mr = mr;
    return x;
  endfunction

  function automatic instr_t NOP();
    instr_t x;
    x = '0;
    return x;
  endfunction

  function automatic step_t S(instr_t i, bit frz, bit fl, logic [21:0] e);
    step_t s;
    s.i = i; s.frz = frz; s.fl = fl; s.exp = e;
    return s;
  endfunction

  task automatic drive(input step_t s);
    @(negedge clk);
    id_valid = s.i.v; id_rs = s.i.rs; id_rt = s.i.rt;
    id_use_rs = s.i.urs; id_use_rt = s.i.urt; id_dest = s.i.dest;
    id_regwrite = s.i.rw; id_memread = s.i.mr;
    freeze = s.frz; flush = s.fl;
    sb.push_back(s.exp);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    id_valid = 1'b0; freeze = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] e;
    #2 rst = 1'b1;
    sb.push_back(ev(0, 0, 0, 1, 0));
    #1;
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset_async: got %s need %s", fmt(obs()), fmt(e));
    end else $display("reset_async: %s", fmt(obs()));
    // hold reset across an edge while ID presents a valid load
    @(negedge clk);
    id_valid = 1'b1; id_rs = 5'd1; id_use_rs = 1'b1; id_dest = 5'd3;
    id_regwrite = 1'b1; id_memread = 1'b1;
    sb.push_back(ev(0, 0, 0, 1, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset_held: got %s need %s", fmt(obs()), fmt(e));
    end else $display("reset_held: %s", fmt(obs()));
    @(negedge clk);
    id_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fwd_ex();
    step_t st[$];
    logic [21:0] e;
    do_reset();
    st.push_back(S(I(1, 2, 1, 1, 3, 1, 0), 0, 0, ev(0, 0, 0, 1, 0)));
    st.push_back(S(I(3, 5, 1, 1, 4, 1, 0), 0, 0, ev(0, 0, 0, 0, 0)));
    st.push_back(S(NOP(),                   0, 0, ev(0, 2, 0, 0, 0)));
    st.push_back(S(NOP(),                   0, 0, ev(0, 0, 0, 1, 0)));
    for (int k = 0; k < st.size(); k++) begin
      drive(st[k]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL fwd_ex[%0d]: got %s need %s", k, fmt(obs()), fmt(e));
      end else $display("fwd_ex[%0d]: %s", k, fmt(obs()));
    end
  endtask

  task automatic test_fwd_wb();
    step_t st[$];
    logic [21:0] e;
    do_reset();
    st.push_back(S(I(1, 2, 1, 1, 3, 1, 0), 0, 0, ev(0, 0, 0, 1, 0)));
    st.push_back(S(NOP(),                   0, 0, ev(0, 0, 0, 0, 0)));
    st.push_back(S(I(2, 3, 1, 1, 6, 1, 0), 0, 0, ev(0, 0, 0, 1, 0)));
    st.push_back(S(NOP(),                   0, 0, ev(0, 0, 1, 0, 0)));
    for (int k = 0; k < st.size(); k++) begin
      drive(st[k]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL fwd_wb[%0d]: got %s need %s", k, fmt(obs()), fmt(e));
      end else $display("fwd_wb[%0d]: %s", k, fmt(obs()));
    end
  endtask

  task automatic test_priority_r0();
    step_t st[$];
    logic [21:0] e;
    do_reset();
    st.push_back(S(I(1, 2, 1, 1, 3, 1, 0), 0, 0, ev(0, 0, 0, 1, 0)));
    st.push_back(S(I(1, 2, 1, 1, 3, 1, 0), 0, 0, ev(0, 0, 0, 0, 0)));
    st.push_back(S(I(3, 3, 1, 1, 7, 1, 0), 0, 0, ev(0, 0, 0, 0, 0)));
    st.push_back(S(I(1, 2, 1, 1, 0, 1, 0), 0, 0, ev(0, 2, 2, 0, 0)));
    st.push_back(S(I(0, 0, 1, 1, 8, 1, 0), 0, 0, ev(0, 0, 0, 0, 0)));
    st.push_back(S(I(0, 0, 1, 1, 9, 1, 0), 0, 0, ev(0, 0, 0, 0, 0)));
    st.push_back(S(NOP(),                   0, 0, ev(0, 0, 0, 0, 0)));
    st.push_back(S(NOP(),                   0, 0, ev(0, 0, 0, 1, 0)));
    for (int k = 0; k < st.size(); k++) begin
      drive(st[k]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL prio_r0[%0d]: got %s need %s", k, fmt(obs()), fmt(e));
      end else $display("prio_r0[%0d]: %s", k, fmt(obs()));
    end
  endtask

  task automatic test_load_use();
    step_t st[$];
    logic [21:0] e;
    do_reset();
    st.push_back(S(I(1, 0, 1, 0, 3, 1, 1), 0, 0, ev(0, 0, 0, 1, 0)));
    st.push_back(S(I(3, 3, 1, 1, 4, 1, 0), 0, 0, ev(1, 0, 0, 0, 0)));
    st.push_back(S(I(3, 3, 1, 1, 4, 1, 0), 0, 0, ev(0, 0, 0, 1, 1)));
    st.push_back(S(NOP(),                   0, 0, ev(0, 1, 1, 0, 1)));
    st.push_back(S(NOP(),                   0, 0, ev(0, 0, 0, 1, 1)));
    for (int k = 0; k < st.size(); k++) begin
      drive(st[k]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL load_use[%0d]: got %s need %s", k, fmt(obs()), fmt(e));
      end else $display("load_use[%0d]: %s", k, fmt(obs()));
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    logic [21:0] e;
    do_reset();
    st.push_back(S(I(1, 0, 1, 0, 3, 1, 1), 0, 0, ev(0, 0, 0, 1, 0)));
    st.push_back(S(I(3, 3, 0, 0, 4, 1, 0), 0, 0, ev(0, 0, 0, 0, 0)));
    st.push_back(S(I(2, 0, 1, 0, 5, 1, 1), 0, 0, ev(0, 0, 0, 0, 0)));
    st.push_back(S(I(5, 5, 0, 1, 6, 1, 0), 0, 0, ev(1, 0, 0, 0, 0)));
    st.push_back(S(I(5, 5, 0, 1, 6, 1, 0), 0, 0, ev(0, 0, 0, 1, 1)));
    st.push_back(S(I(6, 0, 1, 0, 7, 1, 1), 0, 0, ev(0, 0, 1, 0, 1)));
    st.push_back(S(I(7, 7, 1, 0, 8, 1, 0), 0, 0, ev(1, 2, 0, 0, 1)));
    st.push_back(S(I(7, 7, 1, 0, 8, 1, 0), 0, 0, ev(0, 0, 0, 1, 2)));
    st.push_back(S(NOP(),                   0, 0, ev(0, 1, 0, 0, 2)));
    for (int k = 0; k < st.size(); k++) begin
      drive(st[k]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL b2b[%0d]: got %s need %s", k, fmt(obs()), fmt(e));
      end else $display("b2b[%0d]: %s", k, fmt(obs()));
    end
  endtask

  task automatic test_flush();
    step_t st[$];
    logic [21:0] e;
    do_reset();
    st.push_back(S(I(1, 0, 1, 0, 3, 1, 1), 0, 0, ev(0, 0, 0, 1, 0)));
    st.push_back(S(I(3, 3, 1, 1, 4, 1, 0), 0, 1, ev(0, 0, 0, 0, 0)));
    st.push_back(S(NOP(),                   0, 0, ev(0, 0, 0, 1, 0)));
    st.push_back(S(NOP(),                   0, 0, ev(0, 0, 0, 1, 0)));
    for (int k = 0; k < st.size(); k++) begin
      drive(st[k]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL flush[%0d]: got %s need %s", k, fmt(obs()), fmt(e));
      end else $display("flush[%0d]: %s", k, fmt(obs()));
    end
  endtask

  task automatic test_freeze();
    step_t st[$];
    logic [21:0] e;
    do_reset();
    st.push_back(S(I(5, 6, 1, 1, 1, 1, 0), 0, 0, ev(0, 0, 0, 1, 0)));
    st.push_back(S(I(1, 0, 1, 0, 3, 1, 1), 0, 0, ev(0, 0, 0, 0, 0)));
    st.push_back(S(I(3, 3, 1, 1, 4, 1, 0), 1, 0, ev(1, 2, 0, 0, 0)));
    st.push_back(S(I(3, 3, 1, 1, 4, 1, 0), 1, 0, ev(1, 2, 0, 0, 0)));
    st.push_back(S(I(3, 3, 1, 1, 4, 1, 0), 1, 0, ev(1, 2, 0, 0, 0)));
    st.push_back(S(I(3, 3, 1, 1, 4, 1, 0), 0, 0, ev(1, 2, 0, 0, 0)));
    st.push_back(S(I(3, 3, 1, 1, 4, 1, 0), 0, 0, ev(0, 0, 0, 1, 1)));
    st.push_back(S(NOP(),                   0, 0, ev(0, 1, 1, 0, 1)));
    for (int k = 0; k < st.size(); k++) begin
      drive(st[k]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL freeze[%0d]: got %s need %s", k, fmt(obs()), fmt(e));
      end else $display("freeze[%0d]: %s", k, fmt(obs()));
    end
  endtask

  task automatic test_reset_mid();
    step_t st[$];
    logic [21:0] e;
    do_reset();
    st.push_back(S(I(1, 0, 1, 0, 3, 1, 1), 0, 0, ev(0, 0, 0, 1, 0)));
    st.push_back(S(I(3, 3, 1, 1, 4, 1, 0), 0, 0, ev(1, 0, 0, 0, 0)));
    st.push_back(S(I(3, 3, 1, 1, 4, 1, 0), 0, 0, ev(0, 0, 0, 1, 1)));
    st.push_back(S(I(1, 0, 1, 0, 7, 1, 1), 0, 0, ev(0, 1, 1, 0, 1)));
    st.push_back(S(I(7, 2, 1, 1, 9, 1, 0), 0, 0, ev(1, 0, 0, 0, 1)));
    for (int k = 0; k < st.size(); k++) begin
      drive(st[k]);
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL rst_mid[%0d]: got %s need %s", k, fmt(obs()), fmt(e));
      end else $display("rst_mid[%0d]: %s", k, fmt(obs()));
    end
    // reset while the stall is active, no clock edge in between
    rst = 1'b1;
    sb.push_back(ev(0, 0, 0, 1, 0));
    #1;
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL rst_mid_async: got %s need %s", fmt(obs()), fmt(e));
    end else $display("rst_mid_async: %s", fmt(obs()));
    @(negedge clk);
    rst = 1'b0;
    id_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_wb();
    test_priority_r0();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_freeze();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
